// File: rtl/maze_pkg.sv
// Shared maze types for actor movement: direction and tile-class encodings
// plus the steering helpers used by every actor instance.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_UP    = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        TILE_WALL   = 2'b00,
        TILE_OPEN   = 2'b01,
        TILE_PELLET = 2'b10,
        TILE_HOUSE  = 2'b11
    } tile_t;

    // The encoding is chosen so that the opposite direction is the bitwise NOT.
    function automatic dir_t reverse(dir_t d);
        return dir_t'(~d);
    endfunction

    // Clockwise on screen (y grows downward): RIGHT -> DOWN -> LEFT -> UP.
    function automatic dir_t rotate_cw(dir_t d);
        case (d)
            DIR_RIGHT: return DIR_DOWN;
            DIR_DOWN:  return DIR_LEFT;
            DIR_LEFT:  return DIR_UP;
            default:   return DIR_RIGHT;
        endcase
    endfunction

    // Counter-clockwise: RIGHT -> UP -> LEFT -> DOWN.
    function automatic dir_t rotate_ccw(dir_t d);
        case (d)
            DIR_RIGHT: return DIR_UP;
            DIR_UP:    return DIR_LEFT;
            DIR_LEFT:  return DIR_DOWN;
            default:   return DIR_RIGHT;
        endcase
    endfunction

    // Walls are never walkable; house tiles only for actors allowed inside.
    function automatic logic passable(logic [1:0] t, logic house_ok);
        return (t != TILE_WALL) && ((t != TILE_HOUSE) || house_ok);
    endfunction

endpackage

// File: rtl/step_accum.sv
// Fractional speed accumulator: adds speed every enabled tick and emits a
// one-tick step whenever the sum carries out of SPD_W bits.
module step_accum #(
    parameter int SPD_W = 8
) (
    input  logic             clk60,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [SPD_W-1:0] speed,
    output logic             step
);

    logic [SPD_W-1:0] acc;
    logic [SPD_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, speed};
    // Step is combinational so the carry tick is the tick the actor moves.
    assign step    = enable & ~clear & acc_sum[SPD_W];

    // Accumulate while running; clear on spawn, hold while frozen.
    always_ff @(posedge clk60 or negedge reset_n) begin
        if (!reset_n)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (enable)
            acc <= acc_sum[SPD_W-1:0];
    end

endmodule

// File: rtl/actor_motion.sv
// Per-actor maze movement engine: steering request capture, centre-gated
// turning, fractional-speed stepping, and walk animation.
// Optional build macro ACTOR_TUNNEL_WRAP_EN: horizontal tunnel wrap at the
// maze edges; without it those edges behave as walls.
module actor_motion
    import maze_pkg::*;
#(
    parameter int TILE_PX    = 8,
    parameter int CENTER_OFS = 3,
    parameter int MAZE_W_PX  = 224,
    parameter int Y_TILE_OFS = 3,
    parameter int SPAWN_X    = 119,
    parameter int SPAWN_Y    = 227,
    parameter int SPD_W      = 8,
    parameter int REL_MODE   = 1,
    parameter int ANIM_DIV   = 2
) (
    input  logic             clk60,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             spawn,
    input  logic [9:0]       spawn_x,
    input  logic [9:0]       spawn_y,
    input  logic [1:0]       spawn_dir,
    input  logic [SPD_W-1:0] speed,
    input  logic             req_left,
    input  logic             req_right,
    input  logic             req_uturn,
    input  logic [1:0]       req_dir,
    input  logic             req_dir_valid,
    input  logic             house_ok,
    input  logic [3:0][1:0]  tile_info,
    output logic [9:0]       xloc,
    output logic [9:0]       yloc,
    output logic [1:0]       dir,
    output logic [1:0]       anim_cycle,
    output logic [6:0]       tile_x,
    output logic [6:0]       tile_y,
    output logic             at_center,
    output logic             moved
);

    localparam int                 TILE_SH = $clog2(TILE_PX);
    localparam logic [TILE_SH-1:0] CTR     = TILE_SH'(CENTER_OFS);
    localparam logic [9:0]         X_MAX   = 10'(MAZE_W_PX - 1);
    localparam int                 ACW     = $clog2(ANIM_DIV + 1);

    dir_t           cur_dir, queue, queue_cap, dir_n;
    logic [2:0]     btn_s1, btn_s2, btn_rise;   // {uturn, right, left}
    logic [ACW-1:0] anim_cnt;
    logic [9:0]     nx, ny, tx_full, ty_full;
    logic           step, blocked, edge_stop, do_move;

    assign dir       = cur_dir;
    assign at_center = (xloc[TILE_SH-1:0] == CTR) && (yloc[TILE_SH-1:0] == CTR);
    assign tx_full   = xloc >> TILE_SH;
    assign ty_full   = (yloc >> TILE_SH) - 10'(Y_TILE_OFS);
    assign tile_x    = tx_full[6:0];
    assign tile_y    = ty_full[6:0];
    assign btn_rise  = btn_s1 & ~btn_s2;

    step_accum #(.SPD_W(SPD_W)) u_step (
        .clk60   (clk60),
        .reset_n (reset_n),
        .clear   (spawn),
        .enable  (enable),
        .speed   (speed),
        .step    (step)
    );

    // Button edge detectors run every edge so presses during a freeze still queue.
    always_ff @(posedge clk60 or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            btn_s1 <= {req_uturn, req_right, req_left};
            btn_s2 <= btn_s1;
        end
    end

    // New queued direction from this edge's request (relative buttons or joystick).
    always_comb begin
        queue_cap = queue;
        if (REL_MODE != 0) begin
            if (btn_rise[0])      queue_cap = rotate_ccw(cur_dir);
            else if (btn_rise[1]) queue_cap = rotate_cw(cur_dir);
            else if (btn_rise[2]) queue_cap = reverse(cur_dir);
        end else if (req_dir_valid) begin
            queue_cap = dir_t'(req_dir);
        end
    end

    // Turn decision and candidate next position in the (possibly new) direction.
    always_comb begin
        dir_n = cur_dir;
        if (queue_cap == reverse(cur_dir))
            dir_n = queue_cap;
        else if (at_center && passable(tile_info[queue_cap], house_ok))
            dir_n = queue_cap;
        blocked   = at_center && !passable(tile_info[dir_n], house_ok);
        edge_stop = 1'b0;
        nx        = xloc;
        ny        = yloc;
        case (dir_n)
            DIR_UP:   ny = yloc - 10'd1;
            DIR_DOWN: ny = yloc + 10'd1;
            DIR_LEFT: begin
                if (xloc == 10'd0) begin
`ifdef ACTOR_TUNNEL_WRAP_EN
                    nx = X_MAX;
`else
                    edge_stop = 1'b1;
`endif
                end else begin
                    nx = xloc - 10'd1;
                end
            end
            default: begin
                if (xloc == X_MAX) begin
`ifdef ACTOR_TUNNEL_WRAP_EN
                    nx = 10'd0;
`else
                    edge_stop = 1'b1;
`endif
                end else begin
                    nx = xloc + 10'd1;
                end
            end
        endcase
        do_move = step && !blocked && !edge_stop;
    end

    // Actor state: spawn overrides the frame; otherwise queue always, motion only when enabled.
    always_ff @(posedge clk60 or negedge reset_n) begin
        if (!reset_n) begin
            xloc       <= 10'(SPAWN_X);
            yloc       <= 10'(SPAWN_Y);
            cur_dir    <= DIR_RIGHT;
            queue      <= DIR_RIGHT;
            anim_cycle <= 2'd1;
            anim_cnt   <= '0;
            moved      <= 1'b0;
        end else if (spawn) begin
            xloc       <= spawn_x;
            yloc       <= spawn_y;
            cur_dir    <= dir_t'(spawn_dir);
            queue      <= dir_t'(spawn_dir);
            anim_cycle <= 2'd1;
            anim_cnt   <= '0;
            moved      <= 1'b0;
        end else begin
            queue <= queue_cap;
            moved <= 1'b0;
            if (enable) begin
                cur_dir <= dir_n;
                if (do_move) begin
                    xloc  <= nx;
                    yloc  <= ny;
                    moved <= 1'b1;
                    if (anim_cnt == ACW'(ANIM_DIV - 1)) begin
                        anim_cnt   <= '0;
                        anim_cycle <= anim_cycle + 2'd1;
                    end else begin
                        anim_cnt <= anim_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_actor_motion.sv
// Bench for actor_motion: directed vector table, hand-written corner
// sequences, and a randomized run against a behavioural model.
module tb_actor_motion;

`ifdef ACTOR_TUNNEL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic            clk60 = 1'b0;
    logic            reset_n, enable, spawn;
    logic [9:0]      spawn_x, spawn_y;
    logic [1:0]      spawn_dir;
    logic [7:0]      speed;
    logic            req_left, req_right, req_uturn;
    logic [1:0]      req_dir;
    logic            req_dir_valid, house_ok;
    logic [3:0][1:0] tile_info;
    logic [9:0]      xloc, yloc;
    logic [1:0]      dir, anim_cycle;
    logic [6:0]      tile_x, tile_y;
    logic            at_center, moved;

    int n_checks = 0;
    int n_pass   = 0;

    actor_motion dut (
        .clk60(clk60), .reset_n(reset_n), .enable(enable), .spawn(spawn),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
        .speed(speed), .req_left(req_left), .req_right(req_right),
        .req_uturn(req_uturn), .req_dir(req_dir), .req_dir_valid(req_dir_valid),
        .house_ok(house_ok), .tile_info(tile_info),
        .xloc(xloc), .yloc(yloc), .dir(dir), .anim_cycle(anim_cycle),
        .tile_x(tile_x), .tile_y(tile_y), .at_center(at_center), .moved(moved)
    );

    always #5 clk60 = ~clk60;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk60);
        #1;
    endtask

    task automatic do_spawn(input int x, input int y, input int d);
        spawn = 1'b1; enable = 1'b0;
        spawn_x = 10'(x); spawn_y = 10'(y); spawn_dir = 2'(d);
        tick();
        spawn = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    int  mx, my, md, mq, macc, manim, mcnt, mmov;
    bit  p1[3], p2[3];
    int  ccw_tab[4] = '{1, 3, 0, 2};
    int  cw_tab[4]  = '{2, 0, 3, 1};

    function automatic bit walkable(int q);
        int t = int'(tile_info[q]);
        return (t != 0) && (t != 3 || house_ok);
    endfunction

    task automatic m_reset();
        mx = 119; my = 227; md = 0; mq = 0; macc = 0; manim = 1; mcnt = 0; mmov = 0;
        for (int i = 0; i < 3; i++) begin p1[i] = 0; p2[i] = 0; end
    endtask

    // One clock edge of the actor as described by its rules, using current inputs.
    task automatic m_edge();
        bit b[3];
        bit r[3];
        bit ctr, stp;
        int q, nd;
        b[0] = req_left; b[1] = req_right; b[2] = req_uturn;
        for (int i = 0; i < 3; i++) begin
            r[i] = p1[i] && !p2[i];
            p2[i] = p1[i];
            p1[i] = b[i];
        end
        if (spawn) begin
            mx = int'(spawn_x); my = int'(spawn_y); md = int'(spawn_dir); mq = md;
            macc = 0; manim = 1; mcnt = 0; mmov = 0;
            return;
        end
        q = mq;
        if (r[0])      q = ccw_tab[md];
        else if (r[1]) q = cw_tab[md];
        else if (r[2]) q = 3 - md;
        mq = q;
        mmov = 0;
        if (!enable) return;
        ctr = (mx % 8 == 3) && (my % 8 == 3);
        nd = md;
        if (q == 3 - md) nd = q;
        else if (ctr && walkable(q)) nd = q;
        md = nd;
        macc += int'(speed);
        stp = macc >= 256;
        macc = macc % 256;
        if (!stp) return;
        if (ctr && !walkable(nd)) return;
        case (nd)
            0: begin
                if (mx == 223) begin if (!WRAP) return; mx = 0; end
                else mx++;
            end
            3: begin
                if (mx == 0) begin if (!WRAP) return; mx = 223; end
                else mx--;
            end
            1: my = (my + 1023) % 1024;
            default: my = (my + 1) % 1024;
        endcase
        mmov = 1;
        mcnt++;
        if (mcnt == 2) begin mcnt = 0; manim = (manim + 1) % 4; end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int sx, sy, sd;
        logic [7:0] ti;
        int spd;
        bit hok;
        int n;
        int ex, ey, ed, emov;
    } vec_t;
    vec_t vt[11];

    initial begin
        reset_n = 1'b0; enable = 1'b0; spawn = 1'b0;
        spawn_x = '0; spawn_y = '0; spawn_dir = '0; speed = '0;
        req_left = 0; req_right = 0; req_uturn = 0; req_dir = '0; req_dir_valid = 0;
        house_ok = 0; tile_info = 8'h55;

        vt[0]  = '{120, 227, 0, 8'h55, 255, 0, 3, 122, 227, 0, 1};
        vt[1]  = '{123, 227, 0, 8'h54, 255, 0, 5, 123, 227, 0, 0};
        vt[2]  = '{123, 227, 0, 8'h57, 255, 0, 4, 123, 227, 0, 0};
        vt[3]  = '{123, 227, 0, 8'h57, 255, 1, 2, 124, 227, 0, 1};
        vt[4]  = '{123, 227, 0, 8'h55,   0, 0, 8, 123, 227, 0, 0};
        vt[5]  = '{123, 227, 1, 8'h55, 255, 0, 3, 123, 225, 1, 1};
        vt[6]  = '{123, 227, 2, 8'h55, 255, 0, 2, 123, 228, 2, 1};
        vt[7]  = WRAP ? '{0, 227, 3, 8'h55, 255, 0, 2, 223, 227, 3, 1}
                      : '{0, 227, 3, 8'h55, 255, 0, 2,   0, 227, 3, 0};
        vt[8]  = WRAP ? '{223, 100, 0, 8'h55, 255, 0, 2,   0, 100, 0, 1}
                      : '{223, 100, 0, 8'h55, 255, 0, 2, 223, 100, 0, 0};
        vt[9]  = '{5, 227, 3, 8'h55, 128, 0, 4, 3, 227, 3, 1};
        vt[10] = '{123, 203, 3, 8'h55, 255, 0, 2, 122, 203, 3, 1};

        // Reset state
        #12;
        check("rst_x", xloc, 119);     check("rst_y", yloc, 227);
        check("rst_dir", dir, 0);      check("rst_anim", anim_cycle, 1);
        check("rst_moved", moved, 0);  check("rst_tile_x", tile_x, 14);
        check("rst_tile_y", tile_y, 25); check("rst_center", at_center, 0);

        // Half-speed run from spawn point
        @(posedge clk60); #1;
        reset_n = 1'b1; enable = 1'b1; speed = 8'd128; tile_info = 8'h55;
        tick(); check("half_t1_moved", moved, 0);
        tick(); check("half_t2_moved", moved, 1); check("half_t2_x", xloc, 120);
                check("half_t2_anim", anim_cycle, 1);
        tick(); check("half_t3_moved", moved, 0);
        tick(); check("half_t4_anim", anim_cycle, 2);
        repeat (4) tick();
        check("half_t8_center", at_center, 1);
        repeat (2) tick();
        check("half_t10_x", xloc, 124);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            do_spawn(vt[i].sx, vt[i].sy, vt[i].sd);
            tile_info = vt[i].ti; speed = 8'(vt[i].spd); house_ok = vt[i].hok; enable = 1'b1;
            repeat (vt[i].n) tick();
            check($sformatf("vec%0d_x", i), xloc, vt[i].ex);
            check($sformatf("vec%0d_y", i), yloc, vt[i].ey);
            check($sformatf("vec%0d_dir", i), dir, vt[i].ed);
            check($sformatf("vec%0d_moved", i), moved, vt[i].emov);
        end
        house_ok = 0;

        // Queued left turn taken only at the tile centre
        tile_info = 8'h55; speed = 8'd255;
        do_spawn(120, 227, 0);
        enable = 1'b1; req_left = 1'b1; tick();
        req_left = 1'b0; tick();
        check("qturn_e2_dir", dir, 0); check("qturn_e2_x", xloc, 121);
        tick(); tick();
        check("qturn_e4_dir", dir, 0); check("qturn_e4_x", xloc, 123);
        tick();
        check("qturn_e5_dir", dir, 1); check("qturn_e5_y", yloc, 226);
        check("qturn_e5_x", xloc, 123);

        // U-turn mid-tile
        do_spawn(120, 227, 0);
        enable = 1'b1; tick(); tick();
        req_uturn = 1'b1; tick();
        req_uturn = 1'b0; tick();
        check("uturn_dir", dir, 3); check("uturn_x", xloc, 121); check("uturn_moved", moved, 1);

        // Turn into house refused until house_ok
        do_spawn(123, 227, 0);
        tile_info = 8'h5D; house_ok = 1'b0; speed = 8'd0; enable = 1'b1;
        req_left = 1'b1; tick();
        req_left = 1'b0; repeat (4) tick();
        check("house_refuse_dir", dir, 0);
        house_ok = 1'b1; tick();
        check("house_take_dir", dir, 1); check("house_take_y", yloc, 227);
        house_ok = 1'b0;

        // Frozen while enable is low
        tile_info = 8'h55; speed = 8'd255; enable = 1'b0;
        repeat (4) tick();
        check("freeze_x", xloc, 123); check("freeze_y", yloc, 227);
        check("freeze_moved", moved, 0); check("freeze_anim", anim_cycle, 1);

        // Reset asserted mid-move
        do_spawn(50, 227, 0);
        enable = 1'b1; repeat (3) tick();
        #2 reset_n = 1'b0; #1;
        check("midrst_x", xloc, 119); check("midrst_dir", dir, 0);
        check("midrst_moved", moved, 0); check("midrst_anim", anim_cycle, 1);
        enable = 1'b0; #1 reset_n = 1'b1;
        tick();
        check("midrst_idle_x", xloc, 119);

        // Randomized run against the reference model
        reset_n = 1'b0; m_reset(); #2 reset_n = 1'b1;
        for (int it = 0; it < 2000; it++) begin
            logic [39:0] act, exp;
            int r, ty;
            spawn = ($urandom_range(0, 39) == 0);
            if (spawn) begin
                r = $urandom_range(0, 3);
                if (r == 0)      begin spawn_x = 10'd0;   spawn_dir = 2'd3; end
                else if (r == 1) begin spawn_x = 10'd223; spawn_dir = 2'd0; end
                else begin
                    spawn_x = 10'($urandom_range(0, 27) * 8 + 3);
                    spawn_dir = 2'($urandom_range(0, 3));
                end
                spawn_y = 10'($urandom_range(4, 40) * 8 + 3);
            end
            enable    = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 3);
            speed     = (r == 0) ? 8'd255 : (r == 1) ? 8'd0 : 8'($urandom_range(0, 255));
            tile_info = 8'($urandom);
            house_ok  = $urandom_range(0, 1);
            req_left  = ($urandom_range(0, 7) == 0);
            req_right = ($urandom_range(0, 7) == 0);
            req_uturn = ($urandom_range(0, 15) == 0);
            m_edge();
            tick();
            ty  = ((my / 8) - 3) & 127;
            exp = {10'(mx), 10'(my), 2'(md), 2'(manim), 1'(mmov), 7'(mx / 8), 7'(ty),
                   1'((mx % 8 == 3) && (my % 8 == 3))};
            act = {xloc, yloc, dir, anim_cycle, moved, tile_x, tile_y, at_center};
            n_checks++;
            if (act == exp) n_pass++;
            else $display("FAIL rand%0d: got x=%0d y=%0d dir=%0d anim=%0d mv=%0d expected x=%0d y=%0d dir=%0d anim=%0d mv=%0d (raw %h vs %h)",
                          it, xloc, yloc, dir, anim_cycle, moved, mx, my, md, manim, mmov, act, exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/actor_motion.md
Name: actor_motion

Overview:
- Parametrised per-actor movement engine, the successor to the single-purpose player mover.
- Drives one maze actor (player or ghost) at a fractional speed.
- Supports two steering modes: relative (left/right/U-turn buttons) or absolute (joystick direction).
- Handles tunnel wrap and ghost-house access. Instanced once per actor under the game top level, which owns the game-state FSM and the maze RAM.

Parameters:
TILE_PX, 8, tile edge in pixels (power of 2)
CENTER_OFS, 3, pixel offset within a tile that counts as tile centre
MAZE_W_PX, 224, maze width in pixels (wrap span)
Y_TILE_OFS, 3, tile rows above the maze, subtracted from tile_y
SPAWN_X, 119, reset x pixel
SPAWN_Y, 227, reset y pixel
SPD_W, 8, speed/accumulator width
REL_MODE, 1, 1 = relative button steering, 0 = absolute joystick
ANIM_DIV, 2, moved pixels per animation frame advance

Ports:
clk60  in  1  60 Hz frame clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  game running; low = frozen (pause/death/start)
spawn  in  1  load spawn_x/spawn_y/spawn_dir next edge
spawn_x  in  10  spawn x pixel
spawn_y  in  10  spawn y pixel
spawn_dir  in  2  spawn direction
speed  in  SPD_W  step fraction per tick (2^SPD_W = 1 px/tick)
req_left  in  1  rotate CCW request (REL_MODE=1), level input
req_right  in  1  rotate CW request (REL_MODE=1)
req_uturn  in  1  reverse request (REL_MODE=1)
req_dir  in  2  requested absolute direction (REL_MODE=0)
req_dir_valid  in  1  req_dir is valid this tick
house_ok  in  1  ghost-house tiles are walkable for this actor
tile_info  in  2x4  tile class of neighbour in each direction, indexed by dir
xloc  out  10  pixel x
yloc  out  10  pixel y
dir  out  2  current direction
anim_cycle  out  2  animation frame
tile_x  out  7  xloc / TILE_PX
tile_y  out  7  yloc / TILE_PX - Y_TILE_OFS
at_center  out  1  xloc%TILE_PX==CENTER_OFS and yloc%TILE_PX==CENTER_OFS
moved  out  1  pulse: position changed this edge

Behaviour:
- Reset (reset_n low, asynchronous):
  - xloc = SPAWN_X, yloc = SPAWN_Y.
  - dir = RIGHT, queue = RIGHT, accumulator = 0.
  - anim_cycle = 1, moved = 0, edge-detect registers = 0.
- Encodings: RIGHT=00, UP=01, DOWN=10, LEFT=11; reverse = bitwise NOT. Tile classes: WALL=00, OPEN=01, PELLET=10, HOUSE=11.
- Priority per edge: reset > spawn > enable > idle.
- spawn: loads position/direction, queue = spawn_dir, accumulator 0, anim_cycle 1, moved 0. Applies regardless of enable.
- Request capture (every edge, including while enable is low):
  - REL_MODE=1: 2-stage rising-edge detect per button. Priority left > right > uturn. Queue = rotate(dir) or ~dir.
  - REL_MODE=0: queue = req_dir when req_dir_valid. Held value is re-captured each tick.
- Tick (enable high):
  - acc_n = acc + speed, width SPD_W+1. step = carry out; acc keeps the low SPD_W bits.
  - speed = 0 never steps. speed = 2^SPD_W-1 steps on 255 of 256 ticks.
- Direction, evaluated every enabled tick:
  - queue == ~dir: dir_n = queue immediately, at any position.
  - else if at_center and tile_info[queue] != WALL and (tile_info[queue] != HOUSE or house_ok): dir_n = queue.
  - else dir_n = dir.
- Movement (only on step):
  - Blocked when at_center and tile_info[dir_n] is WALL, or HOUSE with house_ok low.
  - Otherwise move 1 px in dir_n.
  - moved = 1 for exactly the edge where the position changed.
- Turn and step in the same tick: the actor moves in the new direction.
- Animation: counter increments on each moved. On reaching ANIM_DIV it clears and anim_cycle += 1 (wraps 3 to 0). anim_cycle holds when not moving, and holds while enable is low.
- Reset asserted mid-move: all state returns to reset values immediately. The first edge after release is idle until enable.

Optional Feature:
- ACTOR_TUNNEL_WRAP_EN defined:
  - Moving LEFT at xloc = 0 goes to MAZE_W_PX-1.
  - Moving RIGHT at xloc = MAZE_W_PX-1 goes to 0.
  - moved = 1 on the wrap.
- ACTOR_TUNNEL_WRAP_EN undefined: the actor stops at those edges (treated as a wall, moved = 0).

Decomposition:
- Package maze_pkg:
  - dir_t enum and the rotate_cw/rotate_ccw/reverse functions.
  - tile_t enum (WALL/OPEN/PELLET/HOUSE).
- Sub-module step_accum: speed accumulator producing the step pulse. Parameter SPD_W; ports clk60, reset_n, clear, enable, speed, step.

Test Plan:
- Reset released, enable=1, speed=128, all tiles OPEN, dir RIGHT from x=119: x increments every 2nd tick; x=124 after 10 ticks; anim_cycle goes 1→2 after 2 moves.
- Actor at centre (123,227) with tile_info[RIGHT]=WALL, speed=255: no movement, moved=0, dir stays RIGHT.
- REL_MODE=1, moving RIGHT at x=120, pulse req_left for 1 tick, tile UP OPEN: dir stays RIGHT until x=123, then becomes UP and y decrements on that tick.
- req_uturn pulse while moving RIGHT mid-tile: dir=LEFT on the next edge and x decrements.
- Queued turn into HOUSE with house_ok=0: turn never taken. With house_ok=1: taken at centre.
- Wrap enabled, dir LEFT at x=0 with step: x=223. Macro off: x stays 0, moved=0.
